// File: rtl/oai222_arc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oai222_arc_pkg
//  Description : Shared definitions for the OAI222 arc sequencer: FSM state
//                encoding, pin index constants, the check count, the
//                two-pin group-code table and the OAI222 truth function.
//  Revision    : 1.0 - initial release
// ============================================================================
package oai222_arc_pkg;

    localparam int NUM_CHECKS = 108;

    // FSM state encoding
    typedef logic [2:0] arc_state_t;
    localparam arc_state_t ST_IDLE   = 3'd0;
    localparam arc_state_t ST_APPLY  = 3'd1;
    localparam arc_state_t ST_SETTLE = 3'd2;
    localparam arc_state_t ST_SAMPLE = 3'd3;
    localparam arc_state_t ST_DONE   = 3'd4;

    // Pin indices; pin p lives on drv bit (5-p)
    localparam logic [2:0] PIN_A1 = 3'd0;
    localparam logic [2:0] PIN_A2 = 3'd1;
    localparam logic [2:0] PIN_B1 = 3'd2;
    localparam logic [2:0] PIN_B2 = 3'd3;
    localparam logic [2:0] PIN_C1 = 3'd4;
    localparam logic [2:0] PIN_C2 = 3'd5;

    // Codes {01,10,11} applied to a non-tested group; every one of them
    // makes that group's OR term true, so the tested pin alone decides ZN.
    localparam logic [5:0] GROUP_CODES = {2'b11, 2'b10, 2'b01};

    function automatic logic [1:0] group_code(input logic [1:0] idx);
        logic [1:0] code;
        case (idx)
            2'd0:    code = GROUP_CODES[1:0];
            2'd1:    code = GROUP_CODES[3:2];
            default: code = GROUP_CODES[5:4];
        endcase
        return code;
    endfunction

    // ZN = NOT((A1|A2)&(B1|B2)&(C1|C2)), drv ordered A1,A2,B1,B2,C1,C2
    function automatic logic oai222_zn(input logic [5:0] d);
        return ~((d[5] | d[4]) & (d[3] | d[2]) & (d[1] | d[0]));
    endfunction

endpackage
`default_nettype wire

// File: rtl/oai222_arc_vecgen.sv
`default_nettype none
// ============================================================================
//  Module      : oai222_arc_vecgen
//  Description : Combinational vector generator. Maps a check coordinate
//                (pin p, side-condition c, phase ph) to the 6-bit cell drive
//                and the expected ZN for that drive.
//  Ports       : i_p      [2:0] tested pin 0..5 (A1..C2)
//                i_c      [3:0] side-condition index 0..8
//                i_ph           value driven on the tested pin
//                o_drv    [5:0] A1,A2,B1,B2,C1,C2
//                o_exp_zn       expected ZN for o_drv
//  Revision    : 1.0 - initial release
// ============================================================================
module oai222_arc_vecgen
    import oai222_arc_pkg::*;
(
    input  logic [2:0] i_p,
    input  logic [3:0] i_c,
    input  logic       i_ph,
    output logic [5:0] o_drv,
    output logic       o_exp_zn
);

    logic [1:0] w_hi_idx;
    logic [1:0] w_lo_idx;
    logic [1:0] w_grp;
    logic [1:0] w_field;
    logic       w_hi_used;

    // c splits into c/3 (first other group) and c%3 (second other group)
    always_comb begin
        w_hi_idx = 2'd0;
        w_lo_idx = 2'd0;
        case (i_c)
            4'd0:    begin w_hi_idx = 2'd0; w_lo_idx = 2'd0; end
            4'd1:    begin w_hi_idx = 2'd0; w_lo_idx = 2'd1; end
            4'd2:    begin w_hi_idx = 2'd0; w_lo_idx = 2'd2; end
            4'd3:    begin w_hi_idx = 2'd1; w_lo_idx = 2'd0; end
            4'd4:    begin w_hi_idx = 2'd1; w_lo_idx = 2'd1; end
            4'd5:    begin w_hi_idx = 2'd1; w_lo_idx = 2'd2; end
            4'd6:    begin w_hi_idx = 2'd2; w_lo_idx = 2'd0; end
            4'd7:    begin w_hi_idx = 2'd2; w_lo_idx = 2'd1; end
            4'd8:    begin w_hi_idx = 2'd2; w_lo_idx = 2'd2; end
            default: begin w_hi_idx = 2'd0; w_lo_idx = 2'd0; end
        endcase
    end

    assign w_grp = i_p[2:1];

    // Walk the groups in A,B,C order; the tested group gets {ph,0} or
    // {0,ph} (partner held low), the others take the two codes in order.
    always_comb begin
        o_drv     = '0;
        w_field   = '0;
        w_hi_used = 1'b0;
        for (int g = 0; g < 3; g++) begin
            if (w_grp == 2'(g)) begin
                w_field = i_p[0] ? {1'b0, i_ph} : {i_ph, 1'b0};
            end else if (!w_hi_used) begin
                w_field   = group_code(w_hi_idx);
                w_hi_used = 1'b1;
            end else begin
                w_field = group_code(w_lo_idx);
            end
            o_drv[5-2*g -: 2] = w_field;
        end
    end

    assign o_exp_zn = oai222_zn(o_drv);

endmodule
`default_nettype wire

// File: rtl/oai222_arc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : oai222_arc_sequencer
//  Description : Sweeps all 108 sensitisation arcs of an OAI222 cell, waits
//                SETTLE cycles per vector, compares ZN against the expected
//                value and reports a saturating error count, pass flag and
//                first-fail index.
//  Ports       : CLK, RN (async active-low reset)
//                start, abort     sweep control
//                zn               cell output under test
//                drv[5:0]         A1,A2,B1,B2,C1,C2 (registered)
//                busy, done, pass status
//                err_cnt[ERRW-1:0], ff_valid, ff_idx[6:0] results
//  Revision    : 1.0 - initial release
// ============================================================================
module oai222_arc_sequencer
    import oai222_arc_pkg::*;
#(
    parameter int SETTLE = 4,
    parameter int ERRW   = 8
) (
    input  logic            CLK,
    input  logic            RN,
    input  logic            start,
    input  logic            abort,
    input  logic            zn,
    output logic [5:0]      drv,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_cnt,
    output logic            ff_valid,
    output logic [6:0]      ff_idx
);

    localparam logic [7:0] C_SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [6:0] C_LAST_K      = 7'(NUM_CHECKS - 1);

    arc_state_t      r_state;
    logic [2:0]      r_p;
    logic [3:0]      r_c;
    logic            r_ph;
    logic [6:0]      r_k;
    logic [7:0]      r_settle;
    logic [5:0]      r_drv;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [ERRW-1:0] r_err;
    logic            r_ffv;
    logic [6:0]      r_ffi;

    logic [5:0]      w_vec_drv;
    logic            w_exp_zn;
    logic            w_mismatch;
    logic [ERRW-1:0] w_err_next;

    oai222_arc_vecgen u_vecgen (
        .i_p      (r_p),
        .i_c      (r_c),
        .i_ph     (r_ph),
        .o_drv    (w_vec_drv),
        .o_exp_zn (w_exp_zn)
    );

    // Counters are stable from APPLY through SAMPLE, so the generator's
    // expected value matches the drive currently held in r_drv.
    assign w_mismatch = (zn != w_exp_zn);
    assign w_err_next = (w_mismatch && (r_err != '1)) ? r_err + 1'b1 : r_err;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state  <= ST_IDLE;
            r_p      <= '0;
            r_c      <= '0;
            r_ph     <= 1'b0;
            r_k      <= '0;
            r_settle <= '0;
            r_drv    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
            r_ffv    <= 1'b0;
            r_ffi    <= '0;
        end else begin
            r_done <= 1'b0;
            // Abort wins over everything, including the final SAMPLE.
            if (abort && (r_state != ST_IDLE)) begin
                r_state <= ST_IDLE;
                r_drv   <= '0;
                r_busy  <= 1'b0;
                r_pass  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_state <= ST_APPLY;
                            r_busy  <= 1'b1;
                            r_err   <= '0;
                            r_pass  <= 1'b0;
                            r_ffv   <= 1'b0;
                            r_ffi   <= '0;
                            r_p     <= '0;
                            r_c     <= '0;
                            r_ph    <= 1'b0;
                            r_k     <= '0;
                        end
                    end
                    ST_APPLY: begin
                        r_drv    <= w_vec_drv;
                        r_settle <= '0;
                        r_state  <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (r_settle == C_SETTLE_LAST) begin
                            r_state <= ST_SAMPLE;
                        end else begin
                            r_settle <= r_settle + 8'd1;
                        end
                    end
                    ST_SAMPLE: begin
                        r_err <= w_err_next;
                        if (w_mismatch && !r_ffv) begin
                            r_ffv <= 1'b1;
                            r_ffi <= r_k;
                        end
                        if (r_k == C_LAST_K) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                            r_drv   <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            // k = p*18 + c*2 + ph: ph fastest, then c, then p
                            r_k  <= r_k + 7'd1;
                            r_ph <= ~r_ph;
                            if (r_ph) begin
                                if (r_c == 4'd8) begin
                                    r_c <= '0;
                                    r_p <= r_p + 3'd1;
                                end else begin
                                    r_c <= r_c + 4'd1;
                                end
                            end
                            r_state <= ST_APPLY;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign drv      = r_drv;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign err_cnt  = r_err;
    assign ff_valid = r_ffv;
    assign ff_idx   = r_ffi;

endmodule
`default_nettype wire

// File: tb/tb_oai222_arc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oai222_arc_sequencer
//  Description : Self-checking bench for oai222_arc_sequencer (SETTLE=4,
//                ERRW=8) plus a second instance with SETTLE=1, ERRW=4 for
//                error-counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oai222_arc_sequencer;

    logic       CLK;
    logic       RN;
    logic       start, abort, zn;
    logic [5:0] drv;
    logic       busy, done, pass, ff_valid;
    logic [7:0] err_cnt;
    logic [6:0] ff_idx;

    logic       start4;
    logic [5:0] drv4;
    logic       busy4, done4, pass4, ffv4;
    logic [3:0] err4;
    logic [6:0] ffi4;

    int   mode;     // 0 golden cell, 1 stuck-1, 2 stuck-0, 3+ bench-driven
    logic zn_var;

    int checks   = 0;
    int failures = 0;

    int m_err, m_ffi;
    bit m_ffv;

    typedef struct {
        int         k;
        logic [5:0] drv;
        logic       zn;
    } vec_t;
    vec_t tbl [108];

    oai222_arc_sequencer #(.SETTLE(4), .ERRW(8)) dut (
        .CLK(CLK), .RN(RN), .start(start), .abort(abort), .zn(zn),
        .drv(drv), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .ff_valid(ff_valid), .ff_idx(ff_idx)
    );

    oai222_arc_sequencer #(.SETTLE(1), .ERRW(4)) dut4 (
        .CLK(CLK), .RN(RN), .start(start4), .abort(1'b0), .zn(1'b0),
        .drv(drv4), .busy(busy4), .done(done4), .pass(pass4),
        .err_cnt(err4), .ff_valid(ffv4), .ff_idx(ffi4)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always_comb begin
        case (mode)
            0:       zn = ~((drv[5] | drv[4]) & (drv[3] | drv[2]) & (drv[1] | drv[0]));
            1:       zn = 1'b1;
            2:       zn = 1'b0;
            default: zn = zn_var;
        endcase
    end

    // Drive for check k straight from the arc rule: pin p gets ph, partner 0,
    // other groups in A,B,C order get codes (c/3)+1 and (c%3)+1.
    function automatic logic [5:0] ref_drv(input int k);
        int p, c, ph, g, oth, cv;
        logic [5:0] d;
        p = k / 18; c = (k % 18) / 2; ph = k % 2; g = p / 2;
        d = '0; oth = 0; cv = 0;
        for (int gg = 0; gg < 3; gg++) begin
            if (gg == g) cv = (p % 2 == 0) ? ph * 2 : ph;
            else begin
                cv = (oth == 0) ? c / 3 + 1 : c % 3 + 1;
                oth++;
            end
            d[5-2*gg] = cv[1];
            d[4-2*gg] = cv[0];
        end
        return d;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_dut();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One sweep of the main instance. zsel 3 drives zn from the table,
    // zsel 4 drives random zn (rnd_pct % wrong) and updates the model.
    task automatic sweep(input int zsel, input int rnd_pct, input bit check_vec,
                         input bit poke_start, output int done_n);
        int k;
        logic refz;
        mode = zsel;
        m_err = 0; m_ffi = 0; m_ffv = 0;
        done_n = -1;
        start_dut();
        for (int n = 1; n <= 1000 && done_n < 0; n++) begin
            k = (n - 1) / 6;
            refz = (k % 2 == 0);
            if (zsel == 3) zn_var = (k < 108) ? tbl[k].zn : 1'b0;
            if (zsel == 4) begin
                zn_var = ($urandom_range(99) < rnd_pct) ? ~refz : refz;
                if (n % 6 == 0 && k < 108 && zn_var != refz) begin
                    if (m_err < 255) m_err++;
                    if (!m_ffv) begin m_ffv = 1; m_ffi = k; end
                end
            end
            if (poke_start) start = (n == 100);
            tick();
            if (check_vec && n % 6 == 3 && n / 6 < 108) begin
                chk($sformatf("drv_k%0d", n / 6), drv, tbl[n / 6].drv);
                if (n / 6 == 37) chk("drv_k37_literal", drv, 6'b011001);
            end
            if (done) done_n = n;
        end
        start = 1'b0;
    endtask

    int  dn;
    bit  seen;

    initial begin
        RN = 1'b0; start = 1'b0; abort = 1'b0; start4 = 1'b0;
        mode = 0; zn_var = 1'b0;
        for (int k = 0; k < 108; k++) tbl[k] = '{k, ref_drv(k), (k % 2 == 0)};

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_drv", drv, 0);      chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);    chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);  chk("rst_ffv", ff_valid, 0);
        chk("rst_ffi", ff_idx, 0);
        @(negedge CLK);
        RN = 1'b1;

        // Table-driven sweep: every drive vector and expected ZN
        sweep(3, 0, 1'b1, 1'b0, dn);
        chk("tbl_done_time", dn, 648);
        chk("tbl_pass", pass, 1);    chk("tbl_err", err_cnt, 0);
        chk("tbl_ffv", ff_valid, 0); chk("tbl_drv0", drv, 0);
        chk("tbl_busy", busy, 0);
        tick();
        chk("tbl_done_pulse", done, 0);

        // Golden cell model
        sweep(0, 0, 1'b0, 1'b0, dn);
        chk("gold_done_time", dn, 648);
        chk("gold_pass", pass, 1);   chk("gold_err", err_cnt, 0);
        chk("gold_ffv", ff_valid, 0);
        tick();

        // zn stuck at 1, with a start pulse mid-sweep that must be ignored
        sweep(1, 0, 1'b0, 1'b1, dn);
        chk("s1_done_time", dn, 648);
        chk("s1_err", err_cnt, 54);  chk("s1_ffv", ff_valid, 1);
        chk("s1_ffi", ff_idx, 1);    chk("s1_pass", pass, 0);
        tick();

        // Saturation on the 4-bit instance, zn stuck at 0
        dn = -1;
        start4 = 1'b1; tick(); start4 = 1'b0;
        for (int n = 1; n <= 600 && dn < 0; n++) begin
            tick();
            if (done4) dn = n;
        end
        chk("sat_done_time", dn, 324);
        chk("sat_err", err4, 15);    chk("sat_ffi", ffi4, 0);
        chk("sat_ffv", ffv4, 1);     chk("sat_pass", pass4, 0);

        // Abort during check 50 (zn stuck at 1: odd checks 1..49 fail)
        mode = 1;
        start_dut();
        repeat (302) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("ab_busy", busy, 0);     chk("ab_drv", drv, 0);
        chk("ab_pass", pass, 0);     chk("ab_done", done, 0);
        chk("ab_err", err_cnt, 25);  chk("ab_ffi", ff_idx, 1);
        chk("ab_ffv", ff_valid, 1);
        seen = 0;
        repeat (20) begin tick(); if (done) seen = 1; end
        chk("ab_no_done", seen, 0);
        chk("ab_err_hold", err_cnt, 25);
        sweep(0, 0, 1'b0, 1'b0, dn);
        chk("ab_resweep_time", dn, 648);
        chk("ab_resweep_pass", pass, 1);
        tick();

        // Randomised zn against the reference model
        for (int r = 0; r < 3; r++) begin
            sweep(4, (r == 0) ? 5 : (r == 1) ? 30 : 60, 1'b0, 1'b0, dn);
            chk($sformatf("rnd%0d_done_time", r), dn, 648);
            chk($sformatf("rnd%0d_err", r), err_cnt, m_err);
            chk($sformatf("rnd%0d_ffv", r), ff_valid, m_ffv);
            if (m_ffv) chk($sformatf("rnd%0d_ffi", r), ff_idx, m_ffi);
            chk($sformatf("rnd%0d_pass", r), pass, (m_err == 0));
            tick();
        end

        // Asynchronous reset mid-sweep
        mode = 1;
        start_dut();
        repeat (200) tick();
        #2 RN = 1'b0;
        #1;
        chk("ar_drv", drv, 0);       chk("ar_busy", busy, 0);
        chk("ar_err", err_cnt, 0);   chk("ar_ffv", ff_valid, 0);
        chk("ar_ffi", ff_idx, 0);    chk("ar_pass", pass, 0);
        chk("ar_done", done, 0);
        @(negedge CLK);
        RN = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        chk("ar_first_start", busy, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("ar_abort_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
